// File: rtl/pipeline_sequencer.sv
`timescale 1ns/1ps
// Stage controller for the four-stage core: warm-up delay, stage advance/enable,
// stall and error halts, single-instruction stepping and retired-instruction count.
//
// state  | meaning
// WARMUP | counting edges after reset until INITIAL_DELAY is reached
// RUN    | stages advance whenever not stalled/errored and step credit allows
// HALT   | stopped by error or stall timeout; only reset exits
module pipeline_sequencer #(
    parameter int INITIAL_DELAY = 0,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_request,
    input  logic        error_in,
    input  logic        step_mode,
    input  logic        step_pulse,
    output logic        stage_enable,
    output logic [1:0]  current_stage,
    output logic [3:0]  stage_onehot,
    output logic        wb_commit,
    output logic        halted,
    output logic        stall_timeout_error,
    output logic [31:0] retired_count
);

    localparam logic [1:0] WARMUP = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALT   = 2'd2;

    localparam logic [31:0] DELAY_L  = 32'(INITIAL_DELAY);
    localparam logic [16:0] TMO_L    = 17'(STALL_TIMEOUT);
    localparam logic        TMO_EN   = (STALL_TIMEOUT != 0);

    logic [1:0]  state_q, state_d;
    logic [1:0]  stage_q, stage_d;
    logic [31:0] warm_q, warm_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  credit_q, credit_d;
    logic        pulse_q, mode_q;
    logic        halted_q, halted_d;
    logic        tmo_q, tmo_d;
    logic [31:0] retired_q, retired_d;

    logic        advance, commit;
    logic        pulse_rise, mode_rise, mode_fall;
    logic [1:0]  neg_stage;

    always_comb begin
        pulse_rise = step_pulse & ~pulse_q;
        mode_rise  = step_mode & ~mode_q;
        mode_fall  = ~step_mode & mode_q;
        neg_stage  = 2'd0 - stage_q;

        advance = (state_q == RUN) & ~stall_request & ~error_in &
                  (~step_mode | (credit_q != 3'd0));
        commit  = advance & (stage_q == 2'd3);

        state_d     = state_q;
        stage_d     = stage_q;
        warm_d      = warm_q;
        stall_cnt_d = stall_cnt_q;
        credit_d    = credit_q;
        halted_d    = halted_q;
        tmo_d       = tmo_q;
        retired_d   = retired_q;

        case (state_q)
            WARMUP: begin
                warm_d = warm_q + 32'd1;
                if (warm_q == DELAY_L) state_d = RUN;
            end
            RUN: begin
                if (error_in) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else if (stall_request) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                    if (TMO_EN && (({1'b0, stall_cnt_q} + 17'd1) == TMO_L)) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                        tmo_d    = 1'b1;
                    end
                end else begin
                    stall_cnt_d = 16'd0;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        if (advance) stage_d = stage_q + 2'd1;
        if (commit) retired_d = retired_q + 32'd1;

        // Entering step mode finishes the in-flight instruction at the IF boundary.
        if (mode_rise) begin
            credit_d = {1'b0, neg_stage};
        end else if (mode_fall) begin
            credit_d = 3'd0;
        end else if (pulse_rise && (credit_q == 3'd0)) begin
            credit_d = 3'd4;
        end else if (advance && step_mode && (credit_q != 3'd0)) begin
            credit_d = credit_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WARMUP;
            stage_q     <= 2'd0;
            warm_q      <= 32'd0;
            stall_cnt_q <= 16'd0;
            credit_q    <= 3'd0;
            pulse_q     <= 1'b0;
            mode_q      <= 1'b0;
            halted_q    <= 1'b0;
            tmo_q       <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            warm_q      <= warm_d;
            stall_cnt_q <= stall_cnt_d;
            credit_q    <= credit_d;
            pulse_q     <= step_pulse;
            mode_q      <= step_mode;
            halted_q    <= halted_d;
            tmo_q       <= tmo_d;
            retired_q   <= retired_d;
        end
    end

    assign stage_enable        = advance;
    assign wb_commit           = commit;
    assign current_stage       = stage_q;
    assign stage_onehot        = 4'b0001 << stage_q;
    assign halted              = halted_q;
    assign stall_timeout_error = tmo_q;
    assign retired_count       = retired_q;

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stage controller for the four-stage (IF, ID, EX, WB) processor core. It produces the pipeline clock enable and stage indication, applies the power-up warm-up delay, and honours memory stall requests. It also halts the core on decode/execute errors or runaway stalls, supports single-instruction stepping for debug, and counts retired instructions. It sits beside the datapath and drives every stage's enable and the writeback commit strobe.

## Interface

Parameters:
- INITIAL_DELAY, 0: edges after reset release spent in warm-up before the first stage advance.
- STALL_TIMEOUT, 255: consecutive stalled edges that force a halt. 0 disables the timeout. Maximum 65535.

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- stall_request  input  1  memory stall. While high, no stage advances.
- error_in  input  1  OR of the decode and execute error flags.
- step_mode  input  1  1 = single-instruction stepping, 0 = free run.
- step_pulse  input  1  debug step request; the rising edge is detected internally.
- stage_enable  output  1  clock enable for pipeline state. When high, the current stage completes at the next edge.
- current_stage  output  2  0=IF, 1=ID, 2=EX, 3=WB.
- stage_onehot  output  4  one-hot decode of current_stage; bit n corresponds to stage n.
- wb_commit  output  1  high in the WB cycle that completes. Commits the PC and rd write.
- halted  output  1  core stopped by an error. Sticky until reset.
- stall_timeout_error  output  1  the halt was caused by the stall timeout.
- retired_count  output  32  number of completed WB stages.

## Operation

- Control states: WARMUP, RUN, HALT.
- While reset_n is low, all registers are forced to reset values immediately:
  - state = WARMUP; current_stage = 0; stage_onehot = 4'b0001.
  - stage_enable = 0; wb_commit = 0; halted = 0; stall_timeout_error = 0; retired_count = 0.
  - Warm-up counter, stall counter, step credit and the step_pulse and step_mode history registers = 0.
- WARMUP:
  - The warm-up counter increments on every edge.
  - The edge at which the counter equals INITIAL_DELAY moves the state to RUN.
  - error_in and stall_request are ignored.
- Advance condition: stage_enable = (state==RUN) & !stall_request & !error_in & (!step_mode | credit!=0). It is combinational.
- On an edge with stage_enable high:
  - current_stage increments modulo 4 (3 -> 0).
  - If step_mode is 1, the step credit decrements.
- wb_commit = stage_enable & (current_stage==3). On each commit edge, retired_count increments, wrapping 0xFFFFFFFF -> 0.
- Error halt: in RUN, an edge with error_in high moves the state to HALT and sets halted=1. current_stage freezes. error_in takes priority over a simultaneous stall_request or stall timeout; stall_timeout_error stays 0 in that case.
- Stall counter:
  - In RUN, the counter increments on each edge with stall_request high and clears on any edge with it low.
  - When STALL_TIMEOUT!=0 and the counter would reach STALL_TIMEOUT, the state moves to HALT and both halted and stall_timeout_error are set.
- HALT: stage_enable = 0 permanently. Only reset_n exits HALT.
- Step credit (range 0..4):
  - Rising edge of step_pulse with credit==0: credit loads 4.
  - Rising edge of step_pulse with credit!=0: ignored.
  - step_mode going 0->1: credit loads (4 - current_stage) mod 4, so the in-flight instruction finishes at the IF boundary.
  - step_mode going 1->0: credit clears and free run resumes.

## Timing

- With INITIAL_DELAY=N, the state becomes RUN at edge N+1 after reset release. The earliest stage_enable=1 is the cycle following that edge.
- stage_enable and wb_commit react combinationally, in the same cycle, to stall_request and error_in.
- Free-run rate is one stage per unstalled cycle, i.e. one instruction per 4 unstalled cycles.
- The step_pulse edge is registered. The first stepped advance is one cycle after the sampling edge, and a step completes after 4 further enabled cycles.
- An asynchronous reset in any state, including mid-stall or mid-step, returns all outputs to their reset values.

## Test plan

- Warm-up: INITIAL_DELAY=3, all inputs 0. Expected: stage_enable first high in cycle 5 after reset release. wb_commit pulses every 4 cycles. retired_count=2 after 8 enabled cycles.
- Stall: hold stall_request high for 10 cycles during EX (STALL_TIMEOUT=255). Expected: current_stage holds at 2 for 10 cycles and advances the cycle stall drops. No halt.
- Timeout: STALL_TIMEOUT=4, stall_request held high. Expected: halted=1 and stall_timeout_error=1 after the 4th stalled edge. stage_enable stays 0 after stall drops.
- Error priority: error_in and stall_request high together during ID. Expected: halted=1, stall_timeout_error=0, current_stage frozen at 1 until reset.
- Step: set step_mode at stage 2, then pulse step_pulse twice. Expected: 2 advances to stage 0. Then one full instruction per pulse, retired_count +1 per pulse. A pulse while credit!=0 is ignored.
- Wrap and reset: preload retired_count to 0xFFFFFFFF. Expected: the next commit gives 0. Asserting reset_n=0 mid-step returns stage 0, credit 0, WARMUP.
